regfile_port_sched: RTL and testbench

//  Single-port scheduler in front of the register file. Each cycle it grants the regfile port to

---
 rtl/regfile_port_sched_pkg.sv | 20 ++
 rtl/regfile_port_sched_commit_queue.sv | 62 ++++++
 rtl/regfile_port_sched.sv | 152 +++++++++++++++
 tb/tb_regfile_port_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_port_sched_pkg.sv
// Shared types for the regfile port scheduler: commit queue entry layout and arbitration states.
package regfile_port_sched_pkg;

    localparam int unsigned GPR_IDX_SIZE = 5;
    localparam int unsigned ROB_IDX_SIZE = 5;
    localparam int unsigned GPR_SIZE     = 64;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic [GPR_IDX_SIZE-1:0] reg_index;
        logic [ROB_IDX_SIZE-1:0] rob_index;
        logic [GPR_SIZE-1:0]     value;
        logic                    set_nzcv;
        nzcv_t                   nzcv;
    } commit_entry_t;

    typedef enum logic [1:0] {IDLE, DISPATCH, COMMIT, FORCED} sched_state_t;

endpackage

// File: rtl/regfile_port_sched_commit_queue.sv
// In-order commit FIFO; exposes per-entry valid and destination index for the dispatch hazard compare.
module regfile_port_sched_commit_queue
    import regfile_port_sched_pkg::*;
#(
    parameter int unsigned CQ_DEPTH = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    push,
    input  commit_entry_t                           push_data,
    input  logic                                    pop,
    output logic                                    full,
    output logic                                    empty,
    output commit_entry_t                           head,
    output logic [CQ_DEPTH-1:0]                     entry_valid,
    output logic [CQ_DEPTH-1:0][GPR_IDX_SIZE-1:0]   entry_reg
);

    localparam int unsigned PW = $clog2(CQ_DEPTH);

    commit_entry_t mem [CQ_DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;

    always_comb begin
        wr_idx = wr_ptr[PW-1:0];
        rd_idx = rd_ptr[PW-1:0];
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
        head   = mem[rd_idx];
        for (int unsigned i = 0; i < CQ_DEPTH; i++) begin
            entry_reg[i] = mem[i].reg_index;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // When full, push and pop hit the same slot; the later set keeps it valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                entry_valid[rd_idx] <= 1'b0;
            end
            if (push) begin
                wr_ptr              <= wr_ptr + 1'b1;
                entry_valid[wr_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_port_sched.sv
// Single regfile port arbiter between decode operand reads and buffered ROB write-backs.
// Optional statistics counters are built when REGFILE_SCHED_STATS_EN is defined.
module regfile_port_sched
    import regfile_port_sched_pkg::*;
#(
    parameter int unsigned CQ_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned ZR_IDX       = 31
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_d_valid,
    output logic                    out_d_ready,
    input  logic [GPR_IDX_SIZE-1:0] in_d_src1,
    input  logic [GPR_IDX_SIZE-1:0] in_d_src2,
    input  logic                    in_rob_valid,
    output logic                    out_rob_ready,
    input  logic [GPR_IDX_SIZE-1:0] in_rob_reg_index,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_rob_index,
    input  logic [GPR_SIZE-1:0]     in_rob_value,
    input  logic                    in_rob_set_nzcv,
    input  nzcv_t                   in_rob_nzcv,
    output logic                    out_rf_dispatch,
    output logic [GPR_IDX_SIZE-1:0] out_rf_src1,
    output logic [GPR_IDX_SIZE-1:0] out_rf_src2,
    output logic                    out_rf_commit,
    output logic [GPR_IDX_SIZE-1:0] out_rf_reg_index,
    output logic [ROB_IDX_SIZE-1:0] out_rf_rob_index,
    output logic [GPR_SIZE-1:0]     out_rf_value,
    output logic                    out_rf_set_nzcv,
    output nzcv_t                   out_rf_nzcv,
    output logic                    out_idle
`ifdef REGFILE_SCHED_STATS_EN
    ,
    output logic [15:0]             out_stat_hazard_stalls,
    output logic [15:0]             out_stat_forced_commits
`endif
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [GPR_IDX_SIZE-1:0] ZR = GPR_IDX_SIZE'(ZR_IDX);

    sched_state_t  state, state_next;
    logic [SW-1:0] starve_cnt, starve_next;
    logic          run;
    logic          q_full, q_empty, q_push;
    commit_entry_t q_head, q_in;
    logic [CQ_DEPTH-1:0]                   q_valid, src_hit;
    logic [CQ_DEPTH-1:0][GPR_IDX_SIZE-1:0] q_reg;
    logic          hazard, commit_grant, dispatch_grant;

    regfile_port_sched_commit_queue #(.CQ_DEPTH(CQ_DEPTH)) u_cq (
        .clk         (in_clk),
        .rst_n       (in_rst_n),
        .push        (q_push),
        .push_data   (q_in),
        .pop         (commit_grant),
        .full        (q_full),
        .empty       (q_empty),
        .head        (q_head),
        .entry_valid (q_valid),
        .entry_reg   (q_reg)
    );

    // Handshakes are held off until the first clock after reset release.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) run <= 1'b0;
        else           run <= 1'b1;
    end

    always_comb begin
        for (int unsigned i = 0; i < CQ_DEPTH; i++) begin
            src_hit[i] = q_valid[i] &&
                         ((in_d_src1 != ZR && q_reg[i] == in_d_src1) ||
                          (in_d_src2 != ZR && q_reg[i] == in_d_src2));
        end
        hazard         = in_d_valid && (|src_hit);
        commit_grant   = run && !q_empty &&
                         (q_full || hazard || !in_d_valid || starve_cnt == STARVE_MAX);
        dispatch_grant = run && in_d_valid && !hazard && !commit_grant;
        out_d_ready    = dispatch_grant;
        out_rob_ready  = run && (!q_full || commit_grant);
        out_idle       = q_empty && !dispatch_grant && !commit_grant;
        q_push         = in_rob_valid && out_rob_ready;
        q_in           = '{reg_index: in_rob_reg_index, rob_index: in_rob_rob_index,
                           value: in_rob_value, set_nzcv: in_rob_set_nzcv, nzcv: in_rob_nzcv};
    end

    always_comb begin
        starve_next = starve_cnt;
        if (commit_grant || q_empty)
            starve_next = '0;
        else if (dispatch_grant && starve_cnt != STARVE_MAX)
            starve_next = starve_cnt + 1'b1;

        state_next = state;
        if (commit_grant)
            state_next = COMMIT;
        else if (dispatch_grant)
            state_next = (starve_next == STARVE_MAX) ? FORCED : DISPATCH;
        else if (q_empty && !in_d_valid)
            state_next = IDLE;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state            <= IDLE;
            starve_cnt       <= '0;
            out_rf_dispatch  <= 1'b0;
            out_rf_src1      <= '0;
            out_rf_src2      <= '0;
            out_rf_commit    <= 1'b0;
            out_rf_reg_index <= '0;
            out_rf_rob_index <= '0;
            out_rf_value     <= '0;
            out_rf_set_nzcv  <= 1'b0;
            out_rf_nzcv      <= '0;
        end else begin
            state           <= state_next;
            starve_cnt      <= starve_next;
            out_rf_dispatch <= dispatch_grant;
            out_rf_commit   <= commit_grant;
            if (dispatch_grant) begin
                out_rf_src1 <= in_d_src1;
                out_rf_src2 <= in_d_src2;
            end
            if (commit_grant) begin
                out_rf_reg_index <= q_head.reg_index;
                out_rf_rob_index <= q_head.rob_index;
                out_rf_value     <= q_head.value;
                out_rf_set_nzcv  <= q_head.set_nzcv;
                out_rf_nzcv      <= q_head.nzcv;
            end
        end
    end

`ifdef REGFILE_SCHED_STATS_EN
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_stat_hazard_stalls  <= '0;
            out_stat_forced_commits <= '0;
        end else begin
            if (hazard && out_stat_hazard_stalls != '1)
                out_stat_hazard_stalls <= out_stat_hazard_stalls + 1'b1;
            if (state_next == FORCED && state != FORCED && out_stat_forced_commits != '1)
                out_stat_forced_commits <= out_stat_forced_commits + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_port_sched.sv
// Scoreboard bench: a queue-based reference model predicts grants; a monitor checks regfile pulses.
module tb_regfile_port_sched;
    import regfile_port_sched_pkg::*;

    localparam int CQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 3;
    localparam logic [4:0] ZR   = 5'd31;

    typedef struct {
        bit          is_commit;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  rob;
        logic [63:0] val;
        logic        sn;
        logic [3:0]  nz;
    } ev_t;

    logic        in_clk = 1'b0;
    logic        in_rst_n;
    logic        in_d_valid, out_d_ready;
    logic [4:0]  in_d_src1, in_d_src2;
    logic        in_rob_valid, out_rob_ready;
    logic [4:0]  in_rob_reg_index, in_rob_rob_index;
    logic [63:0] in_rob_value;
    logic        in_rob_set_nzcv;
    nzcv_t       in_rob_nzcv;
    logic        out_rf_dispatch, out_rf_commit, out_rf_set_nzcv, out_idle;
    logic [4:0]  out_rf_src1, out_rf_src2, out_rf_reg_index, out_rf_rob_index;
    logic [63:0] out_rf_value;
    nzcv_t       out_rf_nzcv;

    ev_t mq[$];
    ev_t sb[$];
    ev_t me;
    int  starve = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    logic dr, rr;

    always #5 in_clk = ~in_clk;

    regfile_port_sched #(.CQ_DEPTH(4), .STARVE_LIMIT(3), .ZR_IDX(31)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n),
        .in_d_valid(in_d_valid), .out_d_ready(out_d_ready),
        .in_d_src1(in_d_src1), .in_d_src2(in_d_src2),
        .in_rob_valid(in_rob_valid), .out_rob_ready(out_rob_ready),
        .in_rob_reg_index(in_rob_reg_index), .in_rob_rob_index(in_rob_rob_index),
        .in_rob_value(in_rob_value), .in_rob_set_nzcv(in_rob_set_nzcv), .in_rob_nzcv(in_rob_nzcv),
        .out_rf_dispatch(out_rf_dispatch), .out_rf_src1(out_rf_src1), .out_rf_src2(out_rf_src2),
        .out_rf_commit(out_rf_commit), .out_rf_reg_index(out_rf_reg_index),
        .out_rf_rob_index(out_rf_rob_index), .out_rf_value(out_rf_value),
        .out_rf_set_nzcv(out_rf_set_nzcv), .out_rf_nzcv(out_rf_nzcv), .out_idle(out_idle)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Every granted transfer must pulse on the regfile port exactly one cycle later.
    always @(negedge in_clk) begin
        if (in_rst_n && (out_rf_dispatch || out_rf_commit)) begin
            chk("rf_exclusive", 64'(out_rf_dispatch & out_rf_commit), 64'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rf_unexpected: got dispatch=%0b commit=%0b required no pulse",
                         out_rf_dispatch, out_rf_commit);
            end else begin
                me = sb.pop_front();
                chk("rf_kind", 64'(out_rf_commit), 64'(me.is_commit));
                if (me.is_commit) begin
                    chk("rf_reg_index", 64'(out_rf_reg_index), 64'(me.a));
                    chk("rf_rob_index", 64'(out_rf_rob_index), 64'(me.rob));
                    chk("rf_value", out_rf_value, me.val);
                    chk("rf_set_nzcv", 64'(out_rf_set_nzcv), 64'(me.sn));
                    chk("rf_nzcv", 64'(out_rf_nzcv), 64'(me.nz));
                end else begin
                    chk("rf_src1", 64'(out_rf_src1), 64'(me.a));
                    chk("rf_src2", 64'(out_rf_src2), 64'(me.b));
                end
            end
        end else if (in_rst_n && sb.size() != 0) begin
            me = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rf_missing: got no pulse required %s",
                     me.is_commit ? "commit" : "dispatch");
        end
    end

    task automatic cycle(input logic dv, input logic [4:0] s1, input logic [4:0] s2,
                         input logic rv, input logic [4:0] rreg, input logic [4:0] rrob,
                         input logic [63:0] rval, input logic rsn, input logic [3:0] rnz);
        ev_t e;
        bit  haz, full, empty, cg, dg, rdy;
        @(negedge in_clk);
        #2;
        in_d_valid = dv; in_d_src1 = s1; in_d_src2 = s2;
        in_rob_valid = rv; in_rob_reg_index = rreg; in_rob_rob_index = rrob;
        in_rob_value = rval; in_rob_set_nzcv = rsn; in_rob_nzcv = rnz;
        #1;
        empty = (mq.size() == 0);
        full  = (mq.size() == CQ_DEPTH);
        haz   = 1'b0;
        if (dv)
            foreach (mq[i])
                if ((s1 != ZR && mq[i].a == s1) || (s2 != ZR && mq[i].a == s2)) haz = 1'b1;
        cg  = !empty && (full || haz || !dv || starve == STARVE_LIMIT);
        dg  = dv && !haz && !cg;
        rdy = !full || cg;
        chk("d_ready", 64'(out_d_ready), 64'(dg));
        chk("rob_ready", 64'(out_rob_ready), 64'(rdy));
        chk("idle", 64'(out_idle), 64'(empty && !cg && !dg));
        dr = out_d_ready;
        rr = out_rob_ready;
        if (cg) begin
            sb.push_back(mq.pop_front());
            starve = 0;
        end else if (empty) begin
            starve = 0;
        end else if (dg && starve < STARVE_LIMIT) begin
            starve++;
        end
        if (dg) begin
            e = '{is_commit: 1'b0, a: s1, b: s2, rob: 5'd0, val: 64'd0, sn: 1'b0, nz: 4'd0};
            sb.push_back(e);
        end
        if (rv && rdy) begin
            e = '{is_commit: 1'b1, a: rreg, b: 5'd0, rob: rrob, val: rval, sn: rsn, nz: rnz};
            mq.push_back(e);
        end
    endtask

    task automatic disp(input logic [4:0] s1, input logic [4:0] s2);
        cycle(1'b1, s1, s2, 1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 4'd0);
    endtask

    task automatic disp_commit(input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] rreg, input logic [63:0] rval);
        cycle(1'b1, s1, s2, 1'b1, rreg, 5'(rreg + 5'd3), rval, rreg[0], rreg[3:0]);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 64'd0, 1'b0, 4'd0);
    endtask

    function automatic logic [4:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return (r < 8) ? 5'(r) : ZR;
    endfunction

    initial begin
        in_rst_n = 1'b0;
        in_d_valid = 1'b1; in_d_src1 = '0; in_d_src2 = '0;
        in_rob_valid = 1'b1; in_rob_reg_index = '0; in_rob_rob_index = '0;
        in_rob_value = '0; in_rob_set_nzcv = 1'b0; in_rob_nzcv = '0;
        #1;
        chk("reset_idle", 64'(out_idle), 64'd1);
        chk("reset_d_ready", 64'(out_d_ready), 64'd0);
        chk("reset_rob_ready", 64'(out_rob_ready), 64'd0);
        chk("reset_rf_dispatch", 64'(out_rf_dispatch), 64'd0);
        chk("reset_rf_commit", 64'(out_rf_commit), 64'd0);
        chk("reset_rf_value", out_rf_value, 64'd0);
        repeat (2) @(negedge in_clk);
        #2;
        in_d_valid = 1'b0; in_rob_valid = 1'b0; in_rst_n = 1'b1;

        // Plain dispatch on an empty queue.
        disp(5'd5, 5'd6);
        drain(2);

        // Read-after-commit hazard holds dispatch until the write issues.
        cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd9, 64'd42, 1'b0, 4'd0);
        disp(5'd5, 5'd7);
        chk("t3_hazard_stall", 64'(dr), 64'd0);
        disp(5'd5, 5'd7);
        chk("t3_dispatch_after", 64'(dr), 64'd1);
        drain(2);

        // Starvation bound: three dispatches then a forced commit.
        disp_commit(5'd1, 5'd2, 5'd10, 64'hA5A5);
        for (int i = 0; i < 5; i++) begin
            disp(5'd1, 5'd2);
            chk("t4_grant_pattern", 64'(dr), (i == 3) ? 64'd0 : 64'd1);
        end
        drain(2);

        // Fill to capacity with dispatch pending; push while full must be accepted.
        for (int i = 0; i < 4; i++) disp_commit(5'd1, 5'd2, 5'(11 + i), 64'(100 + i));
        disp_commit(5'd1, 5'd2, 5'd15, 64'd104);
        chk("t5_full_rob_ready", 64'(rr), 64'd1);
        chk("t5_full_d_ready", 64'(dr), 64'd0);
        drain(6);

        // Zero register is never a hazard.
        disp_commit(5'd1, 5'd2, ZR, 64'd7);
        disp(ZR, ZR);
        chk("t6_zr_no_hazard", 64'(dr), 64'd1);
        drain(3);

        // Reset with three commits queued drops them and any pending grant.
        for (int i = 0; i < 3; i++) disp_commit(5'd1, 5'd2, 5'(20 + i), 64'(200 + i));
        @(negedge in_clk);
        #2;
        in_d_valid = 1'b1; in_rob_valid = 1'b1; in_rst_n = 1'b0;
        #1;
        chk("t1_idle", 64'(out_idle), 64'd1);
        chk("t1_rf_commit", 64'(out_rf_commit), 64'd0);
        chk("t1_rf_dispatch", 64'(out_rf_dispatch), 64'd0);
        chk("t1_d_ready", 64'(out_d_ready), 64'd0);
        chk("t1_rob_ready", 64'(out_rob_ready), 64'd0);
        mq.delete();
        sb.delete();
        starve = 0;
        @(negedge in_clk);
        #2;
        in_d_valid = 1'b0; in_rob_valid = 1'b0; in_rst_n = 1'b1;
        @(posedge in_clk);
        #1;
        chk("t1_rob_ready_after", 64'(out_rob_ready), 64'd1);
        drain(4);

        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 99) < 70), pick(), pick(),
                  1'($urandom_range(0, 99) < 50), pick(), 5'($urandom_range(0, 31)),
                  {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        drain(8);
        @(negedge in_clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("model_queue_drained", 64'(mq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
